// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM stage: memory-op encodings, FSM states,
// and op classification.
package mem_stage_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned MEMOP_W    = 4;

    typedef enum logic [MEMOP_W-1:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Encodings 9..15 are not memory ops and fall through as NOP.
    function automatic logic op_is_mem(input logic [MEMOP_W-1:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic op_is_load(input memop_e op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic [2:0] op_bytes(input memop_e op);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return 3'd2;
            MEM_LW, MEM_SW:          return 3'd4;
            default:                 return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_ld_ext.sv
// Load extender: turns the assembled little-endian byte buffer into the
// sign- or zero-extended register value for the given load op.
module mem_ld_ext
    import mem_stage_pkg::*;
(
    input  logic [REG_W-1:0] i_buf,
    input  memop_e           i_op,
    output logic [REG_W-1:0] o_data
);

    always_comb begin
        o_data = '0;
        case (i_op)
            MEM_LB:  o_data = {{24{i_buf[7]}}, i_buf[7:0]};
            MEM_LH:  o_data = {{16{i_buf[15]}}, i_buf[15:0]};
            MEM_LW:  o_data = i_buf;
            MEM_LBU: o_data = {24'd0, i_buf[7:0]};
            MEM_LHU: o_data = {16'd0, i_buf[15:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: passes ALU results through, and runs loads/stores byte-serially
// over an 8-bit RAM port while stalling the pipeline.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [MEMOP_W-1:0]    memop_i,
    input  logic [REG_W-1:0]      maddr_i,
    input  logic [REG_W-1:0]      sdata_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  stall_req_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic                  ram_wr_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i
);

    state_e                r_state;
    state_e                w_next_state;
    logic [2:0]            r_cnt;
    memop_e                r_op;
    logic [RAM_ADDR_W-1:0] r_addr;
    logic [REG_W-1:0]      r_sdata;
    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg;
    logic [REG_W-1:0]      r_buf;

    logic                  w_in_is_mem;
    logic                  w_is_load;
    logic [2:0]            w_n;
    logic [REG_W-1:0]      w_ext;
    logic                  w_unused_addr;

    assign w_in_is_mem   = op_is_mem(memop_i);
    assign w_is_load     = op_is_load(r_op);
    assign w_n           = op_bytes(r_op);
    assign w_unused_addr = ^maddr_i[REG_W-1:RAM_ADDR_W];

    mem_ld_ext u_ld_ext (
        .i_buf  (r_buf),
        .i_op   (r_op),
        .o_data (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= MEM_NOP;
            r_addr  <= '0;
            r_sdata <= '0;
            r_wd    <= '0;
            r_wreg  <= 1'b0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_in_is_mem) begin
                        r_op    <= memop_e'(memop_i);
                        r_addr  <= maddr_i[RAM_ADDR_W-1:0];
                        r_sdata <= sdata_i;
                        r_wd    <= wd_i;
                        r_wreg  <= wreg_i;
                        r_cnt   <= '0;
                        r_buf   <= '0;
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 3'd1;
                    // Read data lags its address by one cycle, so cycle c fills byte c-1.
                    for (int unsigned k = 0; k < 4; k++) begin
                        if (w_is_load && (r_cnt == 3'(k + 1)))
                            r_buf[8*k +: 8] <= ram_din_i;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        wd_o         = '0;
        wreg_o       = 1'b0;
        wdata_o      = '0;
        stall_req_o  = 1'b0;
        ram_addr_o   = '0;
        ram_wr_o     = 1'b0;
        ram_dout_o   = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    wd_o    = wd_i;
                    wdata_o = wdata_i;
                    if (w_in_is_mem) begin
                        stall_req_o  = 1'b1;
                        w_next_state = ST_ACCESS;
                    end else begin
                        wreg_o = wreg_i;
                    end
                end
                ST_ACCESS: begin
                    stall_req_o = 1'b1;
                    wd_o        = r_wd;
                    if (r_cnt < w_n)
                        ram_addr_o = r_addr + {{(RAM_ADDR_W-3){1'b0}}, r_cnt};
                    if (w_is_load) begin
                        if (r_cnt == w_n)
                            w_next_state = ST_DONE;
                    end else begin
                        ram_wr_o   = 1'b1;
                        ram_dout_o = r_sdata[{r_cnt[1:0], 3'b000} +: 8];
                        if (r_cnt == w_n - 3'd1)
                            w_next_state = ST_DONE;
                    end
                end
                ST_DONE: begin
                    wd_o         = r_wd;
                    w_next_state = ST_IDLE;
                    if (w_is_load) begin
                        wreg_o  = r_wreg;
                        wdata_o = w_ext;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table of pass-through/load/store ops
// plus hand sequences for per-cycle RAM traffic and reset mid-store.
module tb_mem_stage;

    localparam int unsigned AW = 17;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [3:0]  memop_i;
    logic [31:0] maddr_i;
    logic [31:0] sdata_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;
    logic [AW-1:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    mem_stage #(.RAM_ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wd_i        (wd_i),
        .wreg_i      (wreg_i),
        .wdata_i     (wdata_i),
        .memop_i     (memop_i),
        .maddr_i     (maddr_i),
        .sdata_i     (sdata_i),
        .wd_o        (wd_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .stall_req_o (stall_req_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wr_o    (ram_wr_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i)
    );

    // RAM model: 1-cycle read latency, read-before-write.
    always @(posedge clk) begin
        ram_din_i <= mem[ram_addr_o];
        if (ram_wr_o)
            mem[ram_addr_o] = ram_dout_o;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] maddr;
        logic [31:0] sdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] exp_wdata;
        logic        exp_wreg;
        int unsigned exp_stall;
    } vec_t;

    task automatic drive(input logic [3:0] op, input logic [31:0] maddr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        memop_i = op; maddr_i = maddr; sdata_i = sdata;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    endtask

    // Entered at posedge+1; leaves at the next posedge+1 after the result cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int unsigned stalls = 0;
        bit done = 0;
        drive(v.op, v.maddr, v.sdata, v.wd, v.wreg, v.wdata);
        #1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (stall_req_o) begin
                stalls++;
                @(posedge clk); #2;
            end else begin
                done = 1;
            end
        end
        if (!done) $display("FAIL vec%0d timeout got=stalled exp=done", idx);
        chk($sformatf("vec%0d_stall", idx), stalls, v.exp_stall);
        chk($sformatf("vec%0d_wdata", idx), wdata_o, v.exp_wdata);
        chk($sformatf("vec%0d_wreg", idx), {31'd0, wreg_o}, {31'd0, v.exp_wreg});
        chk($sformatf("vec%0d_wd", idx), {27'd0, wd_o}, {27'd0, v.wd});
        @(posedge clk); #1;
    endtask

    vec_t vecs [16];

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[17'h00100] = 8'h78; mem[17'h00101] = 8'h56;
        mem[17'h00102] = 8'h34; mem[17'h00103] = 8'h12;
        mem[17'h00104] = 8'h9A;
        mem[17'h00020] = 8'h80;
        mem[17'h00030] = 8'hFF; mem[17'h00031] = 8'hFF;
        mem[17'h1FFFF] = 8'h34; mem[17'h00000] = 8'h82;

        //          op     maddr         sdata         wd     wreg  wdata         exp_wdata     ewreg stall
        vecs[0]  = '{4'd0, 32'h0,        32'h0,        5'd5,  1'b1, 32'h00000042, 32'h00000042, 1'b1, 0};
        vecs[1]  = '{4'd9, 32'h100,      32'h0,        5'd7,  1'b1, 32'h0000CAFE, 32'h0000CAFE, 1'b1, 0};
        vecs[2]  = '{4'd15,32'h100,      32'h0,        5'd3,  1'b0, 32'h00001234, 32'h00001234, 1'b0, 0};
        vecs[3]  = '{4'd3, 32'h100,      32'h0,        5'd10, 1'b1, 32'h0,        32'h12345678, 1'b1, 6};
        vecs[4]  = '{4'd1, 32'h20,       32'h0,        5'd11, 1'b1, 32'h0,        32'hFFFFFF80, 1'b1, 3};
        vecs[5]  = '{4'd4, 32'h20,       32'h0,        5'd12, 1'b1, 32'h0,        32'h00000080, 1'b1, 3};
        vecs[6]  = '{4'd5, 32'h30,       32'h0,        5'd13, 1'b1, 32'h0,        32'h0000FFFF, 1'b1, 4};
        vecs[7]  = '{4'd2, 32'h1FFFF,    32'h0,        5'd14, 1'b1, 32'h0,        32'hFFFF8234, 1'b1, 4};
        vecs[8]  = '{4'd5, 32'h1FFFF,    32'h0,        5'd15, 1'b1, 32'h0,        32'h00008234, 1'b1, 4};
        vecs[9]  = '{4'd3, 32'h101,      32'h0,        5'd16, 1'b1, 32'h0,        32'h9A123456, 1'b1, 6};
        vecs[10] = '{4'd1, 32'h101,      32'h0,        5'd0,  1'b1, 32'h0,        32'h00000056, 1'b1, 3};
        vecs[11] = '{4'd6, 32'h400,      32'h000000A5, 5'd17, 1'b1, 32'h0,        32'h0,        1'b0, 2};
        vecs[12] = '{4'd4, 32'h400,      32'h0,        5'd18, 1'b1, 32'h0,        32'h000000A5, 1'b1, 3};
        vecs[13] = '{4'd8, 32'h500,      32'h89ABCDEF, 5'd19, 1'b1, 32'h0,        32'h0,        1'b0, 5};
        vecs[14] = '{4'd3, 32'hFFF00500, 32'h0,        5'd20, 1'b1, 32'h0,        32'h89ABCDEF, 1'b1, 6};
        vecs[15] = '{4'd2, 32'h502,      32'h0,        5'd21, 1'b1, 32'h0,        32'hFFFF89AB, 1'b1, 4};

        // Reset: outputs forced low even with a live pass-through op applied.
        rst = 1'b1;
        drive(4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h42);
        @(posedge clk); @(posedge clk); #2;
        chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wd", {27'd0, wd_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LW per-cycle address sequence.
        drive(4'd3, 32'h100, 32'h0, 5'd4, 1'b1, 32'h0);
        #1;
        chk("lw_c0_stall", {31'd0, stall_req_o}, 32'd1);
        chk("lw_c0_wreg", {31'd0, wreg_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            chk($sformatf("lw_addr%0d", k), {15'd0, ram_addr_o}, 32'h100 + k);
            chk($sformatf("lw_wr%0d", k), {31'd0, ram_wr_o}, 32'd0);
        end
        @(posedge clk); #2;
        chk("lw_c5_stall", {31'd0, stall_req_o}, 32'd1);
        @(posedge clk); #2;
        chk("lw_done_stall", {31'd0, stall_req_o}, 32'd0);
        chk("lw_done_wdata", wdata_o, 32'h12345678);
        chk("lw_done_wreg", {31'd0, wreg_o}, 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // SH misaligned: two write cycles then DONE with no register write.
        drive(4'd7, 32'h203, 32'h0001ABCD, 5'd9, 1'b1, 32'h0);
        #1;
        chk("sh_c0_stall", {31'd0, stall_req_o}, 32'd1);
        @(posedge clk); #2;
        chk("sh_c1_wr", {31'd0, ram_wr_o}, 32'd1);
        chk("sh_c1_addr", {15'd0, ram_addr_o}, 32'h203);
        chk("sh_c1_dout", {24'd0, ram_dout_o}, 32'hCD);
        @(posedge clk); #2;
        chk("sh_c2_wr", {31'd0, ram_wr_o}, 32'd1);
        chk("sh_c2_addr", {15'd0, ram_addr_o}, 32'h204);
        chk("sh_c2_dout", {24'd0, ram_dout_o}, 32'hAB);
        @(posedge clk); #2;
        chk("sh_done_stall", {31'd0, stall_req_o}, 32'd0);
        chk("sh_done_wr", {31'd0, ram_wr_o}, 32'd0);
        chk("sh_done_wreg", {31'd0, wreg_o}, 32'd0);
        chk("sh_done_wdata", wdata_o, 32'd0);
        @(posedge clk); #1;
        drive(4'd0, 32'h0, 32'h0, 5'd1, 1'b0, 32'h0);
        chk("sh_mem202", {24'd0, mem[17'h202]}, 32'h00);
        chk("sh_mem203", {24'd0, mem[17'h203]}, 32'hCD);
        chk("sh_mem204", {24'd0, mem[17'h204]}, 32'hAB);
        chk("sh_mem205", {24'd0, mem[17'h205]}, 32'h00);

        // SW aborted by reset while the third byte would be written.
        @(posedge clk); #1;
        drive(4'd8, 32'h300, 32'hDEADBEEF, 5'd6, 1'b1, 32'h0);
        @(posedge clk); #2;
        chk("swr_c1_dout", {24'd0, ram_dout_o}, 32'hEF);
        @(posedge clk); #2;
        chk("swr_c2_dout", {24'd0, ram_dout_o}, 32'hBE);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(4'd0, 32'h0, 32'h0, 5'd2, 1'b1, 32'h77);
        #1;
        chk("swr_rst_wr", {31'd0, ram_wr_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("swr_after_wr", {31'd0, ram_wr_o}, 32'd0);
        chk("swr_after_stall", {31'd0, stall_req_o}, 32'd0);
        chk("swr_after_pass", wdata_o, 32'h77);
        @(posedge clk); #2;
        chk("swr_idle_wr", {31'd0, ram_wr_o}, 32'd0);
        chk("swr_mem300", {24'd0, mem[17'h300]}, 32'hEF);
        chk("swr_mem301", {24'd0, mem[17'h301]}, 32'hBE);
        chk("swr_mem302", {24'd0, mem[17'h302]}, 32'h00);
        chk("swr_mem303", {24'd0, mem[17'h303]}, 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
